// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD frame checker.
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational digit sanitiser: digits above 9 become 0 and raise the invalid flag.
module bcd_digit_check
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] clean,
    output logic             invalid
);

    assign invalid = (digit > BCD_MAX);
    assign clean   = invalid ? '0 : digit;

endmodule

// File: rtl/bcd_frame_checker.sv
// Collects NDIGITS BCD digits into a frame and flags invalid digits.
// Optional macro BCD_FRAME_ERRCNT_EN adds a saturating 8-bit count of bad frames.
module bcd_frame_checker
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [BCD_W-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [BCD_W*NDIGITS-1:0] frame_dout,
    output logic [NDIGITS-1:0]       err_mask,
    output logic                     frame_ok,
    output logic                     done,
    output logic                     busy
`ifdef BCD_FRAME_ERRCNT_EN
    ,
    output logic [7:0]               err_count
`endif
);

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

    state_t                     state_reg, state_next;
    logic [IW-1:0]              index_reg, index_next;
    logic [BCD_W*NDIGITS-1:0]   frame_reg, frame_next, frame_upd;
    logic [NDIGITS-1:0]         err_reg, err_next, err_upd;
    logic                       ok_reg, ok_next;

    logic [BCD_W-1:0]           clean_digit;
    logic                       digit_invalid;
    logic                       accept;

    bcd_digit_check u_digit_check (
        .digit   (din),
        .clean   (clean_digit),
        .invalid (digit_invalid)
    );

    assign din_ready  = (state_reg == ST_COLLECT) && !abort;
    assign accept     = din_valid && din_ready;
    assign done       = (state_reg == ST_DONE);
    assign busy       = (state_reg != ST_IDLE);
    assign frame_dout = frame_reg;
    assign err_mask   = err_reg;
    assign frame_ok   = ok_reg;

    // Only the slot addressed by the current index is written on an accept.
    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_slot
            logic slot_hit;
            assign slot_hit = accept && (index_reg == IW'(gi));
            assign frame_upd[gi*BCD_W +: BCD_W] = slot_hit ? clean_digit
                                                           : frame_reg[gi*BCD_W +: BCD_W];
            assign err_upd[gi] = slot_hit ? digit_invalid : err_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        frame_next = frame_reg;
        err_next   = err_reg;
        ok_next    = ok_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_COLLECT;
                    index_next = '0;
                    frame_next = '0;
                    err_next   = '0;
                    ok_next    = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (accept) begin
                    frame_next = frame_upd;
                    err_next   = err_upd;
                    if (index_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                        ok_next    = ~|err_upd;
                    end else begin
                        index_next = index_reg + IW'(1);
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            index_reg <= '0;
            frame_reg <= '0;
            err_reg   <= '0;
            ok_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            frame_reg <= frame_next;
            err_reg   <= err_next;
            ok_reg    <= ok_next;
        end
    end

`ifdef BCD_FRAME_ERRCNT_EN
    logic [7:0] err_count_reg;
    logic       bad_frame;

    assign bad_frame = (state_reg == ST_COLLECT) && (state_next == ST_DONE) && !ok_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_reg <= '0;
        end else if (bad_frame && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign err_count = err_count_reg;
`endif

endmodule
